// File: rtl/demux_1_2_fifo.sv
// demux_1_2_fifo
//   Buffered 1-to-2 demultiplexer. Words arriving on a single valid/ready
//   input port are steered by in_sel into one of two per-channel FIFOs
//   (a for sel=0, b for sel=1). Each FIFO drains through its own
//   independent valid/ready output port.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data/in_sel       word and destination channel
//   in_valid/in_ready    input handshake (in_ready = selected FIFO not full)
//   a_data/a_valid       head of channel a FIFO, valid when non-empty
//   a_ready              channel a consumer accepts a_data
//   b_data/b_valid/b_ready  same for channel b
//   a_count/b_count      current occupancy of each FIFO

// Per-channel circular buffer. No bypass in either direction: a pushed word
// becomes visible one cycle later, and a full FIFO refuses pushes even when
// it pops in the same cycle.
module demux_1_2_fifo_ch #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   rdy,
   output logic [WIDTH-1:0]       rdata,
   output logic                   valid,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             pop;

   assign valid = (count != '0);
   assign full  = (count == FULL_CNT);
   assign rdata = mem[rd_ptr];
   assign pop   = valid && rdy;

   // Pointers are exactly AW bits wide, so they wrap DEPTH-1 -> 0 for free
   // (DEPTH is a power of two).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module demux_1_2_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_sel,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       a_data,
   output logic                   a_valid,
   input  logic                   a_ready,
   output logic [WIDTH-1:0]       b_data,
   output logic                   b_valid,
   input  logic                   b_ready,
   output logic [$clog2(DEPTH):0] a_count,
   output logic [$clog2(DEPTH):0] b_count
);
   localparam int NUM_CH = 2;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
   logic [NUM_CH-1:0][CW-1:0]    ch_count;
   logic [NUM_CH-1:0]            ch_push, ch_rdy, ch_valid, ch_full;
   logic                         accept;

   // Only the addressed channel's fullness gates the input, so a full
   // channel never blocks traffic for the other one.
   assign in_ready = !ch_full[in_sel];
   assign accept   = in_valid && in_ready;
   assign ch_push  = {accept && in_sel, accept && !in_sel};
   assign ch_rdy   = {b_ready, a_ready};

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      demux_1_2_fifo_ch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (ch_push[c]),
         .wdata (in_data),
         .rdy   (ch_rdy[c]),
         .rdata (ch_data[c]),
         .valid (ch_valid[c]),
         .full  (ch_full[c]),
         .count (ch_count[c])
      );
   end

   assign a_data  = ch_data[0];
   assign a_valid = ch_valid[0];
   assign a_count = ch_count[0];
   assign b_data  = ch_data[1];
   assign b_valid = ch_valid[1];
   assign b_count = ch_count[1];
endmodule

// File: tb/tb_demux_1_2_fifo.sv
module tb_demux_1_2_fifo;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 0, rst_n = 0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_sel = 0, in_valid = 0, in_ready;
   logic [WIDTH-1:0] a_data, b_data;
   logic             a_valid, b_valid, a_ready = 0, b_ready = 0;
   logic [CW-1:0]    a_count, b_count;

   int checks = 0, errors = 0;

   // Reference model: one queue per channel, head = front.
   logic [WIDTH-1:0] qa[$], qb[$];

   demux_1_2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
      .a_count(a_count), .b_count(b_count));

   always #5 clk = ~clk;

   // Set inputs for the coming edge; settle before any comparison.
   task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic ar, input logic br);
      in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
      #1;
   endtask

   // Advance one clock and apply the same transfer to the model.
   task automatic step();
      bit push_ok, pop_a, pop_b;
      @(posedge clk);
      if (!rst_n) begin
         qa.delete(); qb.delete();
      end else begin
         push_ok = in_valid && ((in_sel ? qb.size() : qa.size()) < DEPTH);
         pop_a   = a_ready && qa.size() > 0;
         pop_b   = b_ready && qb.size() > 0;
         if (pop_a) void'(qa.pop_front());
         if (pop_b) void'(qb.pop_front());
         if (push_ok) begin
            if (in_sel) qb.push_back(in_data); else qa.push_back(in_data);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin drive(1, 0, 8'h50 + 8'(i), 0, 0); step(); end
      drive(0, 0, 0, 0, 0);
      checks++; if (a_count !== 3'd3) begin errors++; $display("FAIL pre_reset_count: got %0d exp 3", a_count); end
      #2 rst_n = 0; #1;
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %0b exp 0", a_valid); end
      checks++; if (a_count !== '0) begin errors++; $display("FAIL reset_a_count: got %0d exp 0", a_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b exp 1", in_ready); end
      checks++; if (a_data !== '0 || b_data !== '0) begin errors++; $display("FAIL reset_data: got a=%0h b=%0h exp 0", a_data, b_data); end
      checks++; if (b_valid !== 1'b0 || b_count !== '0) begin errors++; $display("FAIL reset_b: got v=%0b c=%0d exp 0", b_valid, b_count); end
      step(); qa.delete(); qb.delete();
      @(negedge clk); rst_n = 1; #1;
      drive(1, 0, 8'h11, 0, 0); step();
      checks++; if (a_valid !== 1'b1 || a_data !== 8'h11) begin errors++; $display("FAIL post_reset_push: got v=%0b d=%0h exp 1/11", a_valid, a_data); end
      drive(0, 0, 0, 1, 1); step();
   endtask

   task automatic test_deinterleave();
      logic [WIDTH-1:0] w[4];
      w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h03; w[3] = 8'h04;
      for (int i = 0; i < 4; i++) begin
         drive(1, 1'(i % 2), w[i], 1, 1);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL deint_ready%0d: got %0b exp 1", i, in_ready); end
         step();
         if (i % 2 == 0) begin
            checks++; if (a_valid !== 1'b1 || a_data !== w[i] || b_valid !== 1'b0) begin errors++;
               $display("FAIL deint_a%0d: got av=%0b ad=%0h bv=%0b exp 1/%0h/0", i, a_valid, a_data, b_valid, w[i]); end
         end else begin
            checks++; if (b_valid !== 1'b1 || b_data !== w[i] || a_valid !== 1'b0) begin errors++;
               $display("FAIL deint_b%0d: got bv=%0b bd=%0h av=%0b exp 1/%0h/0", i, b_valid, b_data, a_valid, w[i]); end
         end
      end
      drive(0, 0, 0, 1, 1); step();
      checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin errors++; $display("FAIL deint_drain: got av=%0b bv=%0b exp 0/0", a_valid, b_valid); end
   endtask

   task automatic test_fill_block_bypass();
      logic [WIDTH-1:0] exp_a[4];
      for (int i = 0; i < DEPTH; i++) begin drive(1, 0, 8'hA0 + 8'(i), 0, 0); step(); end
      drive(1, 0, 8'hA4, 0, 0);
      checks++; if (in_ready !== 1'b0 || a_count !== 3'd4) begin errors++; $display("FAIL full_block: got rdy=%0b cnt=%0d exp 0/4", in_ready, a_count); end
      step();
      drive(1, 1, 8'hB0, 0, 0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL other_ch_ready: got %0b exp 1", in_ready); end
      step();
      checks++; if (b_count !== 3'd1 || b_data !== 8'hB0) begin errors++; $display("FAIL other_ch_push: got c=%0d d=%0h exp 1/b0", b_count, b_data); end
      // Full with a pop in the same cycle: still no push.
      drive(1, 0, 8'hA4, 1, 0);
      checks++; if (in_ready !== 1'b0 || a_data !== 8'hA0) begin errors++; $display("FAIL no_bypass: got rdy=%0b d=%0h exp 0/a0", in_ready, a_data); end
      step();
      checks++; if (a_count !== 3'd3 || a_data !== 8'hA1) begin errors++; $display("FAIL no_bypass_pop: got c=%0d d=%0h exp 3/a1", a_count, a_data); end
      drive(1, 0, 8'hA4, 0, 0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reenable: got %0b exp 1", in_ready); end
      step();
      checks++; if (a_count !== 3'd4) begin errors++; $display("FAIL refill_count: got %0d exp 4", a_count); end
      exp_a[0] = 8'hA1; exp_a[1] = 8'hA2; exp_a[2] = 8'hA3; exp_a[3] = 8'hA4;
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 1, 1);
         checks++; if (a_valid !== 1'b1 || a_data !== exp_a[i]) begin errors++; $display("FAIL drain_a%0d: got v=%0b d=%0h exp 1/%0h", i, a_valid, a_data, exp_a[i]); end
         step();
      end
      checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got av=%0b bv=%0b exp 0/0", a_valid, b_valid); end
   endtask

   task automatic test_wrap();
      logic [WIDTH-1:0] w;
      for (int i = 0; i < 10; i++) begin
         w = 8'($urandom);
         drive(1, 1, w, 0, 1);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready%0d: got %0b exp 1", i, in_ready); end
         step();
         checks++; if (b_valid !== 1'b1 || b_data !== w || b_count !== 3'd1) begin errors++;
            $display("FAIL wrap%0d: got v=%0b d=%0h c=%0d exp 1/%0h/1", i, b_valid, b_data, b_count, w); end
      end
      drive(0, 0, 0, 1, 1); step();
   endtask

   task automatic test_stall();
      logic [WIDTH-1:0] held, w;
      held = 8'h5C;
      drive(1, 1, held, 1, 0); step();
      for (int i = 0; i < 5; i++) begin
         w = 8'h30 + 8'(i);
         drive(1, 0, w, 1, 0); step();
         checks++; if (b_valid !== 1'b1 || b_data !== held || b_count !== 3'd1) begin errors++;
            $display("FAIL stall_b%0d: got v=%0b d=%0h c=%0d exp 1/%0h/1", i, b_valid, b_data, b_count, held); end
         checks++; if (a_valid !== 1'b1 || a_data !== w || a_count !== 3'd1) begin errors++;
            $display("FAIL stall_a%0d: got v=%0b d=%0h c=%0d exp 1/%0h/1", i, a_valid, a_data, a_count, w); end
      end
      drive(0, 0, 0, 1, 1); step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
         checks++; if (in_ready !== ((in_sel ? qb.size() : qa.size()) < DEPTH)) begin errors++;
            $display("FAIL rnd_ready%0d: got %0b sel=%0b qa=%0d qb=%0d", i, in_ready, in_sel, qa.size(), qb.size()); end
         checks++; if (a_count !== CW'(qa.size()) || b_count !== CW'(qb.size())) begin errors++;
            $display("FAIL rnd_count%0d: got a=%0d b=%0d exp a=%0d b=%0d", i, a_count, b_count, qa.size(), qb.size()); end
         checks++; if (a_valid !== (qa.size() != 0) || (qa.size() != 0 && a_data !== qa[0])) begin errors++;
            $display("FAIL rnd_a%0d: got v=%0b d=%0h exp size=%0d", i, a_valid, a_data, qa.size()); end
         checks++; if (b_valid !== (qb.size() != 0) || (qb.size() != 0 && b_data !== qb[0])) begin errors++;
            $display("FAIL rnd_b%0d: got v=%0b d=%0h exp size=%0d", i, b_valid, b_data, qb.size()); end
         step();
      end
   endtask

   initial begin
      #12;
      test_reset();
      test_deinterleave();
      test_fill_block_bypass();
      test_wrap();
      test_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
